// File: rtl/my_rr_arbiter.sv
// rtl/my_rr_arbiter.sv - three-requester round-robin arbiter with hold timeout and handover gap
// Optional grant/preempt counters are enabled by defining MY_RR_ARBITER_STATS_EN.
module my_rr_arbiter #(
  parameter int HOLD_W   = 5,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             req_c,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             gnt_c,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             preempt
`ifdef MY_RR_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_preempt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] NONE = 2'd3;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt_q, preempt_d;
  logic [2:0]        gnt_q, gnt_d;
  logic              busy_q, busy_d;

  logic [2:0] req_v;
  logic [2:0] own_mask;
  logic [2:0] others;
  logic [1:0] pick;
  logic       owner_req;
  logic       timeout;

  if (CNT_W < 1 || HOLD_MAX < 2 || HOLD_MAX > (2 ** HOLD_W) - 1) begin : g_bad_params
  end

  // First requester after `last` in the cyclic order A -> B -> C -> A.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    int idx;
    rr_pick = NONE;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(last) + k) % 3;
      if (req[idx]) rr_pick = 2'(idx);
    end
  endfunction

  assign req_v = {req_c, req_b, req_a};
  assign pick  = rr_pick(last_q, req_v);

  always_comb begin
    own_mask = 3'b000;
    case (owner_q)
      2'd0:    own_mask = 3'b001;
      2'd1:    own_mask = 3'b010;
      2'd2:    own_mask = 3'b100;
      default: own_mask = 3'b000;
    endcase
  end

  assign owner_req = |(req_v & own_mask);
  assign others    = req_v & ~own_mask;
  assign timeout   = (hold_q == HOLD_W'(HOLD_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= NONE;
      last_q    <= 2'd2;
      hold_q    <= '0;
      preempt_q <= 1'b0;
      gnt_q     <= 3'b000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RELEASE: state_d = (pick != NONE) ? S_GRANT : S_IDLE;
      S_GRANT: begin
        if (!owner_req || (timeout && (|others))) state_d = S_RELEASE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Release takes priority over timeout, so a simultaneous drop never pulses preempt.
  always_comb begin
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        owner_d = pick;
        hold_d  = '0;
      end
      S_GRANT: begin
        if (!owner_req) begin
          owner_d = NONE;
          last_d  = owner_q;
          hold_d  = '0;
        end else if (timeout && (|others)) begin
          owner_d   = NONE;
          last_d    = owner_q;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (!timeout) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        owner_d = NONE;
        hold_d  = '0;
      end
    endcase
    gnt_d  = (owner_d == NONE) ? 3'b000 : (3'b001 << owner_d);
    busy_d = (owner_d != NONE);
  end

  assign gnt_a   = gnt_q[0];
  assign gnt_b   = gnt_q[1];
  assign gnt_c   = gnt_q[2];
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

`ifdef MY_RR_ARBITER_STATS_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_c_q, cnt_p_q;
  logic [2:0]       gnt_rise;

  assign gnt_rise = gnt_d & ~gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
      cnt_p_q <= '0;
    end else begin
      if (gnt_rise[0]) cnt_a_q <= cnt_a_q + CNT_W'(1);
      if (gnt_rise[1]) cnt_b_q <= cnt_b_q + CNT_W'(1);
      if (gnt_rise[2]) cnt_c_q <= cnt_c_q + CNT_W'(1);
      if (preempt_d)   cnt_p_q <= cnt_p_q + CNT_W'(1);
    end
  end

  assign cnt_a       = cnt_a_q;
  assign cnt_b       = cnt_b_q;
  assign cnt_c       = cnt_c_q;
  assign cnt_preempt = cnt_p_q;
`endif

endmodule

// File: tb/tb_my_rr_arbiter.sv
// tb/tb_my_rr_arbiter.sv - directed and random checks of my_rr_arbiter against a behavioural model
module tb_my_rr_arbiter;
  localparam int HM = 4;
  localparam int CW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic       gnt_a, gnt_b, gnt_c;
  logic [1:0] owner;
  logic       busy, preempt;
`ifdef MY_RR_ARBITER_STATS_EN
  logic [CW-1:0] cnt_a, cnt_b, cnt_c, cnt_preempt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Model: owner 3 means nobody; held counts edges seen while owning.
  int m_owner = 3;
  int m_last  = 2;
  int m_held  = 0;
  bit m_pre   = 1'b0;
  int m_cnt[4];

  my_rr_arbiter #(.HOLD_W(5), .HOLD_MAX(HM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
    .owner(owner), .busy(busy), .preempt(preempt)
`ifdef MY_RR_ARBITER_STATS_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_preempt(cnt_preempt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(input bit r, input logic [2:0] q);
    bit found;
    int i;
    m_pre = 1'b0;
    if (r) begin
      m_owner = 3; m_last = 2; m_held = 0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end else if (m_owner != 3) begin
      m_held++;
      if (!q[m_owner]) begin
        m_last = m_owner; m_owner = 3;
      end else if (m_held >= HM && (q & ~(3'b001 << m_owner)) != 3'b000) begin
        m_pre = 1'b1; m_cnt[3]++; m_last = m_owner; m_owner = 3;
      end
    end else begin
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        i = (m_last + k) % 3;
        if (!found && q[i]) begin
          found = 1'b1; m_owner = i; m_held = 0; m_cnt[i]++;
        end
      end
    end
  endfunction

  task automatic step(input bit r, input logic [2:0] q);
    logic [2:0] exp_gnt;
    rst = r; req_a = q[0]; req_b = q[1]; req_c = q[2];
    model_edge(r, q);
    @(posedge clk);
    #1;
    exp_gnt = (m_owner == 3) ? 3'b000 : (3'b001 << m_owner);
    chk("gnt", {29'd0, gnt_c, gnt_b, gnt_a}, {29'd0, exp_gnt});
    chk("owner", {30'd0, owner}, m_owner);
    chk("busy", {31'd0, busy}, (m_owner != 3) ? 1 : 0);
    chk("preempt", {31'd0, preempt}, {31'd0, m_pre});
`ifdef MY_RR_ARBITER_STATS_EN
    chk("cnt_a", {16'd0, cnt_a}, m_cnt[0] % 65536);
    chk("cnt_b", {16'd0, cnt_b}, m_cnt[1] % 65536);
    chk("cnt_c", {16'd0, cnt_c}, m_cnt[2] % 65536);
    chk("cnt_preempt", {16'd0, cnt_preempt}, m_cnt[3] % 65536);
`endif
  endtask

  initial begin
    logic [2:0] q;
    int order[$];
    int rr_exp[4];
    int prev;
    int np;
    int na;
    rr_exp = '{0, 1, 2, 0};
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;

    // Reset then idle
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    repeat (10) step(1'b0, 3'b000);

    // Single requester B
    repeat (4) step(1'b0, 3'b010);
    repeat (3) step(1'b0, 3'b000);

    // Round robin, each owner drops after three grant cycles
    step(1'b1, 3'b000);
    prev = 3;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      q = 3'b111;
      if (m_owner != 3 && m_held == 2) q[m_owner] = 1'b0;
      step(1'b0, q);
      if (prev == 3 && owner != 2'd3) order.push_back(int'(owner));
      prev = int'(owner);
    end
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < order.size()) ? order[i] : 99, rr_exp[i]);

    // Timeout with A and C held constantly
    step(1'b1, 3'b000);
    np = 0;
    repeat (20) begin
      step(1'b0, 3'b101);
      np += int'(preempt);
    end
    chk("timeout_preempts", np, 4);

    // Saturation: lone requester never preempted
    step(1'b1, 3'b000);
    np = 0; na = 0;
    repeat (40) begin
      step(1'b0, 3'b001);
      np += int'(preempt);
      na += int'(gnt_a);
    end
    chk("sat_gnt_cycles", na, 40);
    chk("sat_preempts", np, 0);

    // Reset mid-grant
    step(1'b1, 3'b000);
    repeat (3) step(1'b0, 3'b100);
    chk("mid_gnt_c", {31'd0, gnt_c}, 1);
    step(1'b1, 3'b100);
    chk("mid_rst_owner", {30'd0, owner}, 3);
    step(1'b0, 3'b101);
    chk("post_rst_gnt_a", {31'd0, gnt_a}, 1);

    // Random traffic with occasional reset
    q = 3'b000;
    repeat (600) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(5) == 0) q[b] = ~q[b];
      step(($urandom_range(99) == 0), q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
